// File: rtl/gate_unit_arbiter_if.sv
// Request/response bundle for the shared gate unit arbiter.
// Optional GATE_UNIT_ARB_LOCK_EN adds per-requester req_lock.
interface gate_unit_arbiter_if #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2
);
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_op;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
`ifdef GATE_UNIT_ARB_LOCK_EN
  logic [N-1:0]   req_lock;
`endif
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_data;
  logic [IDW-1:0] resp_id;
  logic           busy;

`ifdef GATE_UNIT_ARB_LOCK_EN
  modport master (
    output req_valid, req_op, req_a, req_b, req_lock, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, busy
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_lock, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, busy
  );
`else
  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, busy
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, busy
  );
`endif
endinterface

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one NAND-built bitwise logic unit.
// Define GATE_UNIT_ARB_LOCK_EN to enable sticky grants via req_lock.
module gate_unit_nand2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = ~(a & b);
endmodule

module gate_unit_core #(
  parameter int W = 8
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  logic [W-1:0] na, nb, nab, f_and, f_or;
  logic [W-1:0] f_nor, x1, x2, f_xor, f_xnor;

  gate_unit_nand2 #(.W(W)) u_na (.a(a), .b(a), .y(na));
  gate_unit_nand2 #(.W(W)) u_nb (.a(b), .b(b), .y(nb));
  gate_unit_nand2 #(.W(W)) u_nab (.a(a), .b(b), .y(nab));
  gate_unit_nand2 #(.W(W)) u_and (.a(nab), .b(nab), .y(f_and));
  gate_unit_nand2 #(.W(W)) u_or (.a(na), .b(nb), .y(f_or));
  gate_unit_nand2 #(.W(W)) u_nor (.a(f_or), .b(f_or), .y(f_nor));
  // Classic 4-NAND XOR reusing nab as the shared first stage
  gate_unit_nand2 #(.W(W)) u_x1 (.a(a), .b(nab), .y(x1));
  gate_unit_nand2 #(.W(W)) u_x2 (.a(b), .b(nab), .y(x2));
  gate_unit_nand2 #(.W(W)) u_xor (.a(x1), .b(x2), .y(f_xor));
  gate_unit_nand2 #(.W(W)) u_xnor (.a(f_xor), .b(f_xor), .y(f_xnor));

  always_comb begin
    y = '0;
    unique case (op)
      3'd0: y = na;
      3'd1: y = nb;
      3'd2: y = nab;
      3'd3: y = f_and;
      3'd4: y = f_or;
      3'd5: y = f_nor;
      3'd6: y = f_xor;
      3'd7: y = f_xnor;
      default: y = '0;
    endcase
  end
endmodule

module gate_unit_arbiter #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  gate_unit_arbiter_if.slave     bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] id_q;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   unit_y;
  logic           resp_valid_q;
  logic [W-1:0]   resp_data_q;
  logic [IDW-1:0] resp_id_q;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW:0]   cand;
  logic [N-1:0]   ready;
  logic           accept;
  logic [IDW-1:0] rr_next;
`ifdef GATE_UNIT_ARB_LOCK_EN
  logic           lock_q;
`endif

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(N))
        cand = cand - (IDW+1)'(N);
      if (!win_found && bus.req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[IDW-1:0];
      end
    end
`ifdef GATE_UNIT_ARB_LOCK_EN
    // A locked previous winner overrides the rotation while it asks
    if (lock_q && bus.req_valid[id_q]) begin
      win_found = 1'b1;
      win_id    = id_q;
    end
`endif
  end

  always_comb begin
    ready = '0;
    if (state_q == IDLE && !rst && win_found)
      ready[win_id] = 1'b1;
  end

  assign accept  = (state_q == IDLE) && win_found;
  assign rr_next = (win_id == IDW'(N-1)) ? '0 : win_id + 1'b1;

  gate_unit_core #(.W(W)) u_core (
    .op(op_q),
    .a (a_q),
    .b (b_q),
    .y (unit_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      id_q   <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (accept) begin
      rr_ptr <= rr_next;
      id_q   <= win_id;
      op_q   <= bus.req_op[3*int'(win_id) +: 3];
      a_q    <= bus.req_a[W*int'(win_id) +: W];
      b_q    <= bus.req_b[W*int'(win_id) +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else if (state_q == EXEC) begin
      resp_valid_q <= 1'b1;
      resp_data_q  <= unit_y;
      resp_id_q    <= id_q;
    end else if (state_q == RESP && bus.resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

`ifdef GATE_UNIT_ARB_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lock_q <= 1'b0;
    else if (accept)
      lock_q <= bus.req_lock[win_id];
    else if (state_q == IDLE && !bus.req_valid[id_q])
      lock_q <= 1'b0;
  end
`endif

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Scoreboard bench for gate_unit_arbiter.
// Build with GATE_UNIT_ARB_LOCK_EN to also exercise req_lock.
module tb_gate_unit_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_unit_arbiter_if #(.N(N), .W(W), .IDW(IDW)) bus ();

  gate_unit_arbiter #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
  } exp_t;

  exp_t sb[$];

  function automatic logic [W-1:0] model(
    input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0: return ~a;
      3'd1: return ~b;
      3'd2: return ~(a & b);
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return ~(a | b);
      3'd6: return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic set_req(input int i, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_op[3*i +: 3] = op;
    bus.req_a[W*i +: W]  = a;
    bus.req_b[W*i +: W]  = b;
    bus.req_valid[i]     = 1'b1;
  endtask

  task automatic wait_grant(output logic [N-1:0] g, output int at,
                            output bit to);
    to = 1'b1; g = '0; at = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        g = bus.req_ready; at = cyc; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_resp(output logic [W-1:0] d, output logic [IDW-1:0] id,
                           output int at, output bit to);
    to = 1'b1; d = '0; id = '0; at = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        d = bus.resp_data; id = bus.resp_id; at = cyc; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0; bus.req_op = '0;
    bus.req_a = '0; bus.req_b = '0;
    bus.resp_ready = 1'b1;
`ifdef GATE_UNIT_ARB_LOCK_EN
    bus.req_lock = '0;
`endif
    set_req(3, 3'd0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.req_ready !== 4'b0000)
      $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
    else n_pass++;
    n_chk++;
    if (bus.resp_valid !== 1'b0)
      $display("FAIL reset_valid: got %b want 0", bus.resp_valid);
    else n_pass++;
    n_chk++;
    if (bus.resp_data !== 8'h00 || bus.resp_id !== 2'd0)
      $display("FAIL reset_data: got %h/%0d want 00/0",
               bus.resp_data, bus.resp_id);
    else n_pass++;
    n_chk++;
    if (bus.busy !== 1'b0)
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    else n_pass++;
    bus.req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [N-1:0] g; logic [W-1:0] d; logic [IDW-1:0] id;
    int at, rat, c0; bit to; exp_t e;
    step();
    set_req(0, 3'd6, 8'hF0, 8'h3C);
    c0 = cyc;
    wait_grant(g, at, to);
    n_chk++;
    if (to || g !== 4'b0001 || at != c0)
      $display("FAIL single_grant: got %b at %0d want 0001 at %0d",
               g, at, c0);
    else n_pass++;
    sb.push_back('{id: 2'd0, data: 8'hCC});
    step();
    bus.req_valid = '0;
    bus.req_a = '1;
    bus.req_b = '0;
    wait_resp(d, id, rat, to);
    n_chk++;
    if (to || rat != at + 2)
      $display("FAIL single_latency: got cycle %0d want %0d", rat, at + 2);
    else n_pass++;
    n_chk++;
    if (to || sb.size() == 0) begin
      $display("FAIL single_resp: timeout %0d queue %0d", to, sb.size());
    end else begin
      e = sb.pop_front();
      if ({id, d} !== e)
        $display("FAIL single_resp: got %0d/%h want %0d/%h",
                 id, d, e.id, e.data);
      else n_pass++;
    end
  endtask

  task automatic test_op_sweep();
    logic [N-1:0] g; logic [W-1:0] d; logic [IDW-1:0] id;
    int at; bit to; exp_t e;
    logic [W-1:0] tbl [8];
    tbl = '{8'h5A, 8'hF0, 8'hFA, 8'h05, 8'hAF, 8'h50, 8'hAA, 8'h55};
    for (int op = 0; op < 8; op++) begin
      step();
      set_req(2, 3'(op), 8'hA5, 8'h0F);
      wait_grant(g, at, to);
      n_chk++;
      if (to || g !== 4'b0100)
        $display("FAIL sweep_grant op%0d: got %b want 0100", op, g);
      else n_pass++;
      sb.push_back('{id: 2'd2, data: tbl[op]});
      step();
      bus.req_valid = '0;
      bus.req_a[W*2 +: W] = W'($urandom);
      bus.req_b[W*2 +: W] = W'($urandom);
      wait_resp(d, id, at, to);
      n_chk++;
      if (to || sb.size() == 0) begin
        $display("FAIL sweep_resp op%0d: timeout %0d", op, to);
      end else begin
        e = sb.pop_front();
        if ({id, d} !== e)
          $display("FAIL sweep_resp op%0d: got %0d/%h want %0d/%h",
                   op, id, d, e.id, e.data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] g, ev; logic [W-1:0] d; logic [IDW-1:0] id;
    int at, prev; bit to; exp_t e;
    logic [2:0]   ro [N];
    logic [W-1:0] ra [N], rb [N];
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      ro[i] = 3'(2*i + 1);
      ra[i] = W'($urandom);
      rb[i] = W'($urandom);
      set_req(i, ro[i], ra[i], rb[i]);
    end
    prev = -1;
    for (int k = 0; k < 5; k++) begin
      ev = '0;
      ev[k % N] = 1'b1;
      wait_grant(g, at, to);
      n_chk++;
      if (to || g !== ev)
        $display("FAIL rr_grant %0d: got %b want %b", k, g, ev);
      else n_pass++;
      if (k > 0) begin
        n_chk++;
        if (at - prev != 3)
          $display("FAIL rr_interval %0d: got %0d want 3", k, at - prev);
        else n_pass++;
      end
      prev = at;
      sb.push_back('{id: IDW'(k % N),
                     data: model(ro[k%N], ra[k%N], rb[k%N])});
      step();
      if (k == 4) bus.req_valid = '0;
      wait_resp(d, id, at, to);
      n_chk++;
      if (to || sb.size() == 0) begin
        $display("FAIL rr_resp %0d: timeout %0d", k, to);
      end else begin
        e = sb.pop_front();
        if ({id, d} !== e)
          $display("FAIL rr_resp %0d: got %0d/%h want %0d/%h",
                   k, id, d, e.id, e.data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] g; logic [W-1:0] d; logic [IDW-1:0] id;
    int at, hs; bit to; exp_t e;
    step();
    bus.resp_ready = 1'b0;
    set_req(1, 3'd6, 8'h96, 8'h0F);
    wait_grant(g, at, to);
    n_chk++;
    if (to || g !== 4'b0010)
      $display("FAIL bp_grant: got %b want 0010", g);
    else n_pass++;
    sb.push_back('{id: 2'd1, data: 8'h99});
    step();
    bus.req_valid = '0;
    set_req(2, 3'd4, 8'h30, 8'h03);
    wait_resp(d, id, at, to);
    n_chk++;
    if (to || sb.size() == 0) begin
      $display("FAIL bp_resp: timeout %0d", to);
    end else begin
      e = sb.pop_front();
      if ({id, d} !== e)
        $display("FAIL bp_resp: got %0d/%h want %0d/%h",
                 id, d, e.id, e.data);
      else n_pass++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== 8'h99 ||
          bus.resp_id !== 2'd1 || bus.req_ready !== 4'b0000 ||
          bus.busy !== 1'b1)
        $display("FAIL bp_hold %0d: got v%b %h/%0d rdy %b busy %b",
                 k, bus.resp_valid, bus.resp_data, bus.resp_id,
                 bus.req_ready, bus.busy);
      else n_pass++;
    end
    step();
    bus.resp_ready = 1'b1;
    hs = cyc;
    wait_grant(g, at, to);
    n_chk++;
    if (to || g !== 4'b0100 || at != hs + 1)
      $display("FAIL bp_next_grant: got %b at %0d want 0100 at %0d",
               g, at, hs + 1);
    else n_pass++;
    n_chk++;
    if (bus.resp_valid !== 1'b0 || bus.resp_data !== 8'h99 ||
        bus.resp_id !== 2'd1)
      $display("FAIL bp_after_hs: got v%b %h/%0d want v0 99/1",
               bus.resp_valid, bus.resp_data, bus.resp_id);
    else n_pass++;
    sb.push_back('{id: 2'd2, data: 8'h33});
    step();
    bus.req_valid = '0;
    wait_resp(d, id, at, to);
    n_chk++;
    if (to || sb.size() == 0) begin
      $display("FAIL bp_resp2: timeout %0d", to);
    end else begin
      e = sb.pop_front();
      if ({id, d} !== e)
        $display("FAIL bp_resp2: got %0d/%h want %0d/%h",
                 id, d, e.id, e.data);
      else n_pass++;
    end
  endtask

  task automatic test_reset_exec();
    logic [N-1:0] g; logic [W-1:0] d; logic [IDW-1:0] id;
    int at, c0, extra; bit to; exp_t e;
    step();
    set_req(0, 3'd3, 8'hFF, 8'h5A);
    wait_grant(g, at, to);
    n_chk++;
    if (to || g !== 4'b0001)
      $display("FAIL rx_grant0: got %b want 0001", g);
    else n_pass++;
    sb.push_back('{id: 2'd0, data: 8'h5A});
    step();
    bus.req_valid = '0;
    set_req(3, 3'd2, 8'hF0, 8'hFF);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    n_chk++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.req_ready !== 4'b0000)
      $display("FAIL rx_in_reset: got v%b busy %b rdy %b",
               bus.resp_valid, bus.busy, bus.req_ready);
    else n_pass++;
    step();
    rst = 1'b0;
    c0 = cyc;
    wait_grant(g, at, to);
    n_chk++;
    if (to || g !== 4'b1000 || at != c0)
      $display("FAIL rx_grant3: got %b at %0d want 1000 at %0d",
               g, at, c0);
    else n_pass++;
    sb.push_back('{id: 2'd3, data: 8'h0F});
    step();
    bus.req_valid = '0;
    wait_resp(d, id, at, to);
    n_chk++;
    if (to || sb.size() == 0) begin
      $display("FAIL rx_resp: timeout %0d", to);
    end else begin
      e = sb.pop_front();
      if ({id, d} !== e)
        $display("FAIL rx_resp: got %0d/%h want %0d/%h",
                 id, d, e.id, e.data);
      else n_pass++;
    end
    extra = 0;
    step();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.resp_valid) extra++;
    end
    n_chk++;
    if (extra != 0 || sb.size() != 0)
      $display("FAIL rx_no_extra: got %0d extra resp, queue %0d want 0/0",
               extra, sb.size());
    else n_pass++;
  endtask

`ifdef GATE_UNIT_ARB_LOCK_EN
  task automatic test_lock();
    logic [N-1:0] g, ev; logic [W-1:0] d; logic [IDW-1:0] id;
    int at; bit to; exp_t e;
    int seq [5];
    logic [W-1:0] la [3];
    seq = '{0, 1, 1, 1, 2};
    la  = '{8'h12, 8'h34, 8'h56};
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req_lock = 4'b0010;
    for (int i = 0; i < 3; i++) set_req(i, 3'd6, la[i], 8'hFF);
    for (int k = 0; k < 5; k++) begin
      ev = '0;
      ev[seq[k]] = 1'b1;
      wait_grant(g, at, to);
      n_chk++;
      if (to || g !== ev)
        $display("FAIL lock_grant %0d: got %b want %b", k, g, ev);
      else n_pass++;
      sb.push_back('{id: IDW'(seq[k]),
                     data: model(3'd6, la[seq[k]], 8'hFF)});
      step();
      if (k == 2) bus.req_lock = '0;
      if (k == 4) bus.req_valid = '0;
      wait_resp(d, id, at, to);
      n_chk++;
      if (to || sb.size() == 0) begin
        $display("FAIL lock_resp %0d: timeout %0d", k, to);
      end else begin
        e = sb.pop_front();
        if ({id, d} !== e)
          $display("FAIL lock_resp %0d: got %0d/%h want %0d/%h",
                   k, id, d, e.id, e.data);
        else n_pass++;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_op_sweep();
    test_round_robin();
    test_backpressure();
    test_reset_exec();
`ifdef GATE_UNIT_ARB_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end
endmodule
